// File: rtl/logic8_arbiter_pkg.sv
// rtl/logic8_arbiter_pkg.sv - shared op and FSM state encodings for logic8_arbiter
package logic8_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/logic8_arbiter_if.sv
// rtl/logic8_arbiter_if.sv - request/result bundle between two requesters, consumer and arbiter
interface logic8_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [WIDTH-1:0] inA0;
    logic [WIDTH-1:0] inB0;
    logic [WIDTH-1:0] inA1;
    logic [WIDTH-1:0] inB1;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [WIDTH-1:0] out;
    logic             outValid;
    logic             outId;
    logic             outReady;
    logic [7:0]       grantCount0;
    logic [7:0]       grantCount1;

    modport slave (
        input  reqValid, inA0, inB0, inA1, inB1, op0, op1, outReady,
        output reqReady, out, outValid, outId, grantCount0, grantCount1
    );

    modport master (
        output reqValid, inA0, inB0, inA1, inB1, op0, op1, outReady,
        input  reqReady, out, outValid, outId, grantCount0, grantCount1
    );
endinterface

// File: rtl/logic8_unit.sv
// rtl/logic8_unit.sv - combinational WIDTH-bit bitwise logic unit
module logic8_unit
    import logic8_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = '0;
        case (op_e'(op))
            OP_OR:  out = inA | inB;
            OP_AND: out = inA & inB;
            OP_XOR: out = inA ^ inB;
            OP_NOT: out = ~inA;
        endcase
    end

endmodule

// File: rtl/logic8_arbiter.sv
// rtl/logic8_arbiter.sv - round-robin share of one logic unit between two requesters
module logic8_arbiter
    import logic8_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            resetN,
    logic8_arbiter_if.slave bus
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             id_q, id_d;
    logic [7:0]       cnt0_q, cnt0_d;
    logic [7:0]       cnt1_q, cnt1_d;

    logic             grant0, grant1;
    logic [WIDTH-1:0] unit_a, unit_b, unit_out;
    logic [1:0]       unit_op;

    // Grant only from IDLE and never while reset is held; ptr_q names the preferred requester.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (resetN && state_q == ST_IDLE) begin
            if (bus.reqValid[0] && (!ptr_q || !bus.reqValid[1])) begin
                grant0 = 1'b1;
            end else if (bus.reqValid[1]) begin
                grant1 = 1'b1;
            end
        end
    end

    assign unit_a  = grant1 ? bus.inA1 : bus.inA0;
    assign unit_b  = grant1 ? bus.inB1 : bus.inB0;
    assign unit_op = grant1 ? bus.op1  : bus.op0;

    logic8_unit #(.WIDTH(WIDTH)) u_unit (
        .inA (unit_a),
        .inB (unit_b),
        .op  (unit_op),
        .out (unit_out)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        id_d    = id_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ST_HOLD;
                    out_d   = unit_out;
                    id_d    = grant1;
                    ptr_d   = grant0;
                    if (grant0) begin
                        cnt0_d = cnt0_q + 8'd1;
                    end else begin
                        cnt1_d = cnt1_q + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.outReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            out_q   <= '0;
            id_q    <= 1'b0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            id_q    <= id_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.reqReady    = {grant1, grant0};
    assign bus.out         = out_q;
    assign bus.outValid    = (state_q == ST_HOLD);
    assign bus.outId       = id_q;
    assign bus.grantCount0 = cnt0_q;
    assign bus.grantCount1 = cnt1_q;

endmodule

// File: tb/tb_logic8_arbiter.sv
// tb/tb_logic8_arbiter.sv - directed stimulus against a transaction-level model of logic8_arbiter
module tb_logic8_arbiter;
    import logic8_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   cmp_en = 1'b0;

    logic8_arbiter_if #(.WIDTH(8)) bus ();

    logic8_arbiter #(.WIDTH(8)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: one result outstanding, a preferred requester, two counters.
    bit         m_busy = 1'b0;
    int         m_pref = 0;
    logic [7:0] m_out = 8'd0;
    int         m_id = 0;
    int         m_cnt[2] = '{0, 0};

    function automatic logic [7:0] m_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic int m_pick(input logic [1:0] v, input int pref);
        if (v[pref]) return pref;
        if (v[1 - pref]) return 1 - pref;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!resetN) begin
            m_busy = 1'b0; m_pref = 0; m_out = 8'd0; m_id = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (!m_busy) begin
            g = m_pick(bus.reqValid, m_pref);
            if (g >= 0) begin
                m_out  = (g == 0) ? m_calc(bus.inA0, bus.inB0, bus.op0) : m_calc(bus.inA1, bus.inB1, bus.op1);
                m_id   = g;
                m_busy = 1'b1;
                m_pref = 1 - g;
                m_cnt[g] = (m_cnt[g] + 1) % 256;
            end
        end else if (bus.outReady) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [1:0] exp_ready;
        if (cmp_en) begin
            exp_ready = 2'b00;
            if (resetN && !m_busy) begin
                g = m_pick(bus.reqValid, m_pref);
                if (g == 0) exp_ready = 2'b01;
                else if (g == 1) exp_ready = 2'b10;
            end
            chk("m_reqReady", bus.reqReady, exp_ready);
            chk("m_outValid", bus.outValid, m_busy);
            if (m_busy) begin
                chk("m_out", bus.out, m_out);
                chk("m_outId", bus.outId, m_id[0]);
            end
            chk("m_cnt0", bus.grantCount0, m_cnt[0][7:0]);
            chk("m_cnt1", bus.grantCount1, m_cnt[1][7:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        bus.reqValid = 2'b11;
        bus.outReady = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        #1;
        @(negedge clk);
        chk("rst_reqReady", bus.reqReady, 2'b00);
        chk("rst_outValid", bus.outValid, 1'b0);
        chk("rst_out", bus.out, 8'h00);
        chk("rst_outId", bus.outId, 1'b0);
        chk("rst_cnt0", bus.grantCount0, 8'd0);
        chk("rst_cnt1", bus.grantCount1, 8'd0);
        step();
        resetN = 1'b1;
        bus.reqValid = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ng;
        int order[4];
        logic [7:0] ops_exp[4];
        bus.reqValid = 2'b00; bus.outReady = 1'b0;
        bus.inA0 = 8'h00; bus.inB0 = 8'h00; bus.op0 = 2'b00;
        bus.inA1 = 8'h00; bus.inB1 = 8'h00; bus.op1 = 2'b00;

        // Single request, consumer accepts
        do_reset();
        bus.inA0 = 8'b10101010; bus.inB0 = 8'b01010101; bus.op0 = OP_OR; bus.reqValid = 2'b01;
        @(negedge clk); chk("single_ready", bus.reqReady, 2'b01);
        step(); bus.reqValid = 2'b00;
        @(negedge clk);
        chk("single_valid", bus.outValid, 1'b1);
        chk("single_out", bus.out, 8'hFF);
        chk("single_id", bus.outId, 1'b0);
        chk("single_cnt0", bus.grantCount0, 8'd1);
        step(); bus.outReady = 1'b1;
        @(negedge clk); chk("single_hold", bus.outValid, 1'b1);
        step(); bus.outReady = 1'b0;
        @(negedge clk); chk("single_drop", bus.outValid, 1'b0);

        // Round robin with both requesters held valid
        do_reset();
        bus.inA0 = 8'h0F; bus.inB0 = 8'hF0; bus.op0 = OP_XOR;
        bus.inA1 = 8'h34; bus.inB1 = 8'h00; bus.op1 = OP_NOT;
        bus.reqValid = 2'b11; bus.outReady = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus.reqReady != 2'b00) begin
                order[ng] = bus.reqReady[1] ? 1 : 0;
                ng++;
            end
            step();
        end
        bus.reqValid = 2'b00;
        chk("rr_grants", ng, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
        @(negedge clk);
        chk("rr_cnt0", bus.grantCount0, 8'd2);
        chk("rr_cnt1", bus.grantCount1, 8'd2);

        // Backpressure on requester 1 while requester 0 waits
        do_reset();
        bus.inA1 = 8'hC3; bus.inB1 = 8'hF0; bus.op1 = OP_OR; bus.reqValid = 2'b10;
        @(negedge clk); chk("bp_ready", bus.reqReady, 2'b10);
        step(); bus.reqValid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_out", bus.out, 8'hF3);
            chk("bp_id", bus.outId, 1'b1);
            chk("bp_valid", bus.outValid, 1'b1);
            chk("bp_ready_hold", bus.reqReady, 2'b00);
            step();
            if (i == 4) bus.outReady = 1'b1;
        end
        bus.outReady = 1'b0;
        @(negedge clk);
        chk("bp_release", bus.outValid, 1'b0);
        chk("bp_next_grant", bus.reqReady, 2'b01);

        // All four operations
        do_reset();
        ops_exp = '{8'h76, 8'h34, 8'h42, 8'hCB};
        bus.inA0 = 8'h34; bus.inB0 = 8'h76;
        for (int op = 0; op < 4; op++) begin
            bus.op0 = op[1:0]; bus.reqValid = 2'b01;
            @(negedge clk); chk("ops_ready", bus.reqReady, 2'b01);
            step(); bus.reqValid = 2'b00; bus.outReady = 1'b1;
            @(negedge clk); chk("ops_out", bus.out, ops_exp[op]);
            step(); bus.outReady = 1'b0;
        end

        // Reset while a result is pending
        do_reset();
        bus.inA0 = 8'h12; bus.inB0 = 8'h34; bus.op0 = OP_AND; bus.reqValid = 2'b11;
        @(negedge clk); chk("rh_first", bus.reqReady, 2'b01);
        step();
        @(negedge clk); chk("rh_valid", bus.outValid, 1'b1);
        step(); resetN = 1'b0;
        @(negedge clk); chk("rh_ready_in_reset", bus.reqReady, 2'b00);
        step(); resetN = 1'b1;
        @(negedge clk);
        chk("rh_outValid", bus.outValid, 1'b0);
        chk("rh_out", bus.out, 8'h00);
        chk("rh_cnt0", bus.grantCount0, 8'd0);
        chk("rh_regrant", bus.reqReady, 2'b01);
        step(); bus.reqValid = 2'b00;

        // Counter wrap after 256 grants
        do_reset();
        bus.reqValid = 2'b01; bus.outReady = 1'b1;
        ng = 0;
        for (int c = 0; c < 600 && ng < 256; c++) begin
            @(negedge clk);
            if (bus.reqReady[0]) ng++;
            step();
        end
        bus.reqValid = 2'b00;
        chk("wrap_grants", ng, 256);
        @(negedge clk);
        chk("wrap_cnt0", bus.grantCount0, 8'd0);
        step(); bus.outReady = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
